// File: rtl/rom_dec_pkg.sv
// Shared types and constants for the ROM-driven down-stepper.
// DEC_ROM holds the predecessor of every code, including the wrap at zero.
package rom_dec_pkg;

    localparam int WIDTH = 4;
    localparam int DEPTH = 1 << WIDTH;

    localparam logic [WIDTH:0] REM_FULL = (WIDTH + 1)'(DEPTH);
    localparam logic [WIDTH:0] REM_ONE  = (WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [DEPTH-1:0][WIDTH-1:0] rom_t;

    function automatic rom_t build_dec_rom();
        rom_t t;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) begin
                t[i] = WIDTH'(DEPTH - 1);
            end else begin
                t[i] = WIDTH'(i - 1);
            end
        end
        return t;
    endfunction

    localparam rom_t DEC_ROM = build_dec_rom();

endpackage

// File: rtl/rom_dec_lut.sv
// Combinational predecessor lookup; wrap flags the entry that came from code 0.
module rom_dec_lut
    import rom_dec_pkg::*;
(
    input  logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] data,
    output logic             wrap
);

    assign data = DEC_ROM[addr];
    assign wrap = (addr == {WIDTH{1'b0}});

endmodule

// File: rtl/rom_decrementer_seq.sv
// Loads a seed and streams successive ROM predecessors over valid/ready,
// then pulses done for one cycle.
module rom_decrementer_seq
    import rom_dec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] steps,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_wrap,
    output logic             busy,
    output logic             done
);

    state_t           state_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] lut_addr_s;
    logic [WIDTH-1:0] lut_data_s;
    logic             lut_wrap_s;
    logic             handshake_s;

    assign handshake_s = out_valid & out_ready;

    // One shared lookup: seed while idle, the value on the bus otherwise
    always_comb begin
        lut_addr_s = out_data;
        case (state_r)
            IDLE:    lut_addr_s = start_val;
            default: lut_addr_s = out_data;
        endcase
    end

    rom_dec_lut u_lut (
        .addr (lut_addr_s),
        .data (lut_data_s),
        .wrap (lut_wrap_s)
    );

    // Sequencer FSM owning the step counter and all output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            rem_r     <= {(WIDTH + 1){1'b0}};
            out_data  <= {WIDTH{1'b0}};
            out_valid <= 1'b0;
            out_wrap  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        out_data  <= lut_data_s;
                        out_wrap  <= lut_wrap_s;
                        rem_r     <= (steps == {WIDTH{1'b0}}) ? REM_FULL : {1'b0, steps};
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= RUN;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                RUN: begin
                    if (handshake_s) begin
                        if (rem_r > REM_ONE) begin
                            out_data <= lut_data_s;
                            out_wrap <= lut_wrap_s;
                            rem_r    <= rem_r - REM_ONE;
                        end else begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state_r   <= DONE;
                        end
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
